// File: rtl/vpu_pkg.sv
// Shared VPU definitions: opcode encoding, issue-controller FSM states and opcode helpers.
// Used by vpu_issue_ctrl, vpu_issue_agen and the VPU ALU.
package vpu_pkg;

  localparam int unsigned VpuOpW = 4;

  typedef enum logic [VpuOpW-1:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpRelu  = 4'd2,
    OpMul   = 4'd3,
    OpDRelu = 4'd4
  } vpu_opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } issue_state_e;

  // Unary ops take only operand0; operand1 is not fetched.
  function automatic logic is_unary(logic [VpuOpW-1:0] op);
    return (op == VpuOpW'(OpRelu)) || (op == VpuOpW'(OpDRelu));
  endfunction

  function automatic logic is_legal(logic [VpuOpW-1:0] op);
    return op <= VpuOpW'(OpDRelu);
  endfunction

endpackage

// File: rtl/vpu_issue_agen.sv
// Element counter and base+offset address generators for the VPU issue controller.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                restart the element counter at 0 (command accept)
//   advance_i              one read issued this cycle; step the counter
//   len_i                  latched element count
//   src0_i/src1_i/dst_i    latched base addresses
//   wr_idx_i               element index of the write currently being formed
//   idx_o, last_o          current read element index, index is the final element
//   rd0_addr_o/rd1_addr_o  read addresses (src + idx, wrapping)
//   wr_addr_o              write address (dst + wr_idx, wrapping)
module vpu_issue_agen
  import vpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] src0_i,
  input  logic [ADDR_W-1:0] src1_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  wr_idx_i,
  output logic [LEN_W-1:0]  idx_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] rd0_addr_o,
  output logic [ADDR_W-1:0] rd1_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (advance_i) begin
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Address arithmetic wraps modulo 2^ADDR_W.
  always_comb begin
    idx_o      = cnt_q;
    last_o     = (cnt_q == (len_i - LEN_W'(1)));
    rd0_addr_o = src0_i + ADDR_W'(cnt_q);
    rd1_addr_o = src1_i + ADDR_W'(cnt_q);
    wr_addr_o  = dst_i + ADDR_W'(wr_idx_i);
  end

endmodule

// File: rtl/vpu_issue_ctrl.sv
// Initiator side of the VPU op interface. Accepts one vector command, streams element pairs
// from the scratchpad into the combinational VPU ALU and writes each result back, one element
// per cycle with a three-stage pipeline (A: read, B: VPU, C: write). A done pulse (with err for
// an illegal opcode) closes each command.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only when idle)
//   cmd_opcode/len/src0/src1/dst       command fields, latched on accept
//   rd0_*/rd1_*                        scratchpad read ports, 1-cycle data latency
//   vpu_start/opcode/operand0/1        VPU request, vpu_result is its combinational answer
//   wr_en/wr_addr/wr_data              registered scratchpad write
//   done, err                          end-of-command pulse and illegal-opcode flag
// Build option: define VPU_ISSUE_PERF_EN to add saturating counters perf_elems (writes) and
// perf_busy (non-idle cycles).
module vpu_issue_ctrl
  import vpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_src0,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rd0_en,
  output logic [ADDR_W-1:0] rd0_addr,
  input  logic [DATA_W-1:0] rd0_data,
  output logic              rd1_en,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [DATA_W-1:0] rd1_data,
  output logic              vpu_start,
  output logic [OP_W-1:0]   vpu_opcode,
  output logic [DATA_W-1:0] vpu_operand0,
  output logic [DATA_W-1:0] vpu_operand1,
  input  logic [DATA_W-1:0] vpu_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
`ifdef VPU_ISSUE_PERF_EN
  output logic [31:0]       perf_elems,
  output logic [31:0]       perf_busy,
`endif
  output logic              done,
  output logic              err
);

  issue_state_e state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] src0_q, src1_q, dst_q;
  logic              err_q;

  logic              b_valid_q;
  logic [LEN_W-1:0]  idx_b_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              accept, cmd_legal, rd_issue, op_unary, last;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] gen_rd0_addr, gen_rd1_addr, gen_wr_addr;

  assign accept    = cmd_valid && (state_q == StIdle);
  assign cmd_legal = is_legal(VpuOpW'(cmd_opcode));
  assign rd_issue  = (state_q == StRun);
  assign op_unary  = is_unary(VpuOpW'(op_q));

  vpu_issue_agen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_agen (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (accept),
    .advance_i  (rd_issue),
    .len_i      (len_q),
    .src0_i     (src0_q),
    .src1_i     (src1_q),
    .dst_i      (dst_q),
    .wr_idx_i   (idx_b_q),
    .idx_o      (idx),
    .last_o     (last),
    .rd0_addr_o (gen_rd0_addr),
    .rd1_addr_o (gen_rd1_addr),
    .wr_addr_o  (gen_wr_addr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = ((cmd_len != '0) && cmd_legal) ? StRun : StDone;
        end
      end
      StRun: begin
        if (last) state_d = StDrain;
      end
      // Stage B empty and stage C holding a write means the final write is on the bus.
      StDrain: begin
        if (wr_en_q && !b_valid_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      len_q     <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      dst_q     <= '0;
      err_q     <= 1'b0;
      b_valid_q <= 1'b0;
      idx_b_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd_opcode;
        len_q  <= cmd_len;
        src0_q <= cmd_src0;
        src1_q <= cmd_src1;
        dst_q  <= cmd_dst;
        err_q  <= !cmd_legal;
      end
      b_valid_q <= rd_issue;
      idx_b_q   <= rd_issue ? idx : '0;
      wr_en_q   <= b_valid_q;
      wr_addr_q <= b_valid_q ? gen_wr_addr : '0;
      wr_data_q <= b_valid_q ? vpu_result : '0;
    end
  end

  always_comb begin
    cmd_ready    = (state_q == StIdle);
    rd0_en       = rd_issue;
    rd0_addr     = rd_issue ? gen_rd0_addr : '0;
    rd1_en       = rd_issue && !op_unary;
    rd1_addr     = rd1_en ? gen_rd1_addr : '0;
    vpu_start    = b_valid_q;
    vpu_opcode   = b_valid_q ? op_q : '0;
    vpu_operand0 = b_valid_q ? rd0_data : '0;
    vpu_operand1 = (b_valid_q && !op_unary) ? rd1_data : '0;
    wr_en        = wr_en_q;
    wr_addr      = wr_addr_q;
    wr_data      = wr_data_q;
    done         = (state_q == StDone);
    err          = (state_q == StDone) && err_q;
  end

`ifdef VPU_ISSUE_PERF_EN
  logic [31:0] perf_elems_q, perf_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_elems_q <= '0;
      perf_busy_q  <= '0;
    end else begin
      if (wr_en_q && (perf_elems_q != '1)) perf_elems_q <= perf_elems_q + 32'd1;
      if ((state_q != StIdle) && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_elems = perf_elems_q;
  assign perf_busy  = perf_busy_q;
`endif

endmodule
